// File: rtl/cam_line_streamer_if.sv
// Camera pins plus UART TX/RX handshake seen by the line streamer.
// The slave side is the streamer; the master side drives the camera and UART.
interface cam_line_streamer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ybuss;
  logic              vsync;
  logic              href;
  logic              pclk;
  logic [DATA_W-1:0] tx_data;
  logic              new_tx_data;
  logic              tx_busy;
  logic [7:0]        rx_data;
  logic              new_rx_data;

  modport master (
    output ybuss, vsync, href, pclk, tx_busy, rx_data, new_rx_data,
    input  tx_data, new_tx_data
  );

  modport slave (
    input  ybuss, vsync, href, pclk, tx_busy, rx_data, new_rx_data,
    output tx_data, new_tx_data
  );
endinterface

// File: rtl/cam_line_streamer.sv
// Camera-to-UART streamer: captures single pixels or whole lines into a FIFO
// and drains them to the UART, appending a 16-bit pixel count after each line.
module cam_line_streamer #(
  parameter int         DATA_W     = 8,
  parameter int         FIFO_DEPTH = 16,
  parameter int         MAX_PIXELS = 640,
  parameter logic [7:0] CMD_PIXEL  = 8'h68,
  parameter logic [7:0] CMD_LINE   = 8'h6C,
  parameter logic [7:0] CMD_ABORT  = 8'h78
) (
  input  logic                 clk,
  input  logic                 rst,
  cam_line_streamer_if.slave   bus,
  output logic                 busy_o,
  output logic                 overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, PIXEL_WAIT, LINE_ARM, LINE_CAPTURE, DRAIN_ONLY, TRAILER_DRAIN
  } state_t;

  state_t            state_q;
  logic [2:0]        pclkSync_q, hrefSync_q, vsyncSync_q;
  logic [DATA_W-1:0] ybuss1_q, ybuss2_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wrPtr_q, rdPtr_q;
  logic [15:0]       count_q;
  logic [1:0]        trailerIdx_q;
  logic [DATA_W-1:0] txData_q;
  logic              newTx_q;
  logic              overflow_q;

  logic              pixStrobe, hrefRise, hrefFall, vsyncRise;
  logic              isAbort, fifoEmpty, fifoFull, trailerSend;
  logic              txFire, pop, pushReq, pushOk, drop, capHit;
  logic [15:0]       countInc;
  logic [DATA_W-1:0] txData_d;

  // Bit 1 is the second synchroniser stage, bit 2 its previous value.
  assign pixStrobe = pclkSync_q[1] & ~pclkSync_q[2] & hrefSync_q[1];
  assign hrefRise  = hrefSync_q[1] & ~hrefSync_q[2];
  assign hrefFall  = ~hrefSync_q[1] & hrefSync_q[2];
  assign vsyncRise = vsyncSync_q[1] & ~vsyncSync_q[2];

  assign isAbort   = bus.new_rx_data && (bus.rx_data == CMD_ABORT) && (state_q != IDLE);
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  assign trailerSend = (state_q == TRAILER_DRAIN) && fifoEmpty && (trailerIdx_q != 2'd2);
  assign txFire      = (!fifoEmpty || trailerSend) && !bus.tx_busy && !newTx_q && !isAbort;
  assign pop         = txFire && !fifoEmpty;

  assign pushReq  = pixStrobe && ((state_q == PIXEL_WAIT) || (state_q == LINE_CAPTURE)) && !isAbort;
  assign pushOk   = pushReq && (!fifoFull || pop);
  assign drop     = pushReq && !pushOk;
  assign countInc = count_q + 16'd1;
  assign capHit   = (state_q == LINE_CAPTURE) && pushOk && (countInc == 16'(MAX_PIXELS));

  assign txData_d = !fifoEmpty ? mem_q[rdPtr_q[AW-1:0]] :
                    (trailerIdx_q == 2'd0) ? DATA_W'(count_q[15:8]) : DATA_W'(count_q[7:0]);

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= ybuss2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pclkSync_q   <= '0;
      hrefSync_q   <= '0;
      vsyncSync_q  <= '0;
      ybuss1_q     <= '0;
      ybuss2_q     <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      trailerIdx_q <= '0;
      txData_q     <= '0;
      newTx_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      pclkSync_q  <= {pclkSync_q[1:0], bus.pclk};
      hrefSync_q  <= {hrefSync_q[1:0], bus.href};
      vsyncSync_q <= {vsyncSync_q[1:0], bus.vsync};
      ybuss1_q    <= bus.ybuss;
      ybuss2_q    <= ybuss1_q;

      newTx_q <= txFire;
      if (txFire) txData_q <= txData_d;
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)    rdPtr_q <= rdPtr_q + 1'b1;
      if (drop)   overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (bus.new_rx_data && bus.rx_data == CMD_PIXEL) begin
            state_q <= PIXEL_WAIT;
          end else if (bus.new_rx_data && bus.rx_data == CMD_LINE) begin
            state_q      <= LINE_ARM;
            count_q      <= '0;
            trailerIdx_q <= '0;
            overflow_q   <= 1'b0;
          end
        end
        PIXEL_WAIT:   if (pushOk) state_q <= DRAIN_ONLY;
        LINE_ARM:     if (hrefRise) state_q <= LINE_CAPTURE;
        LINE_CAPTURE: begin
          if (pushOk) count_q <= countInc;
          if (hrefFall || vsyncRise || capHit) state_q <= TRAILER_DRAIN;
        end
        DRAIN_ONLY:   if (fifoEmpty && !newTx_q) state_q <= IDLE;
        TRAILER_DRAIN: begin
          if (trailerSend && txFire) trailerIdx_q <= trailerIdx_q + 2'd1;
          if (trailerIdx_q == 2'd2 && !newTx_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Abort wins over everything: flush the FIFO by snapping the read pointer.
      if (isAbort) begin
        state_q <= IDLE;
        rdPtr_q <= wrPtr_q;
      end
    end
  end

  assign bus.tx_data     = txData_q;
  assign bus.new_tx_data = newTx_q;
  assign busy_o          = (state_q != IDLE);
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_cam_line_streamer.sv
// Self-checking bench: two streamers (default cap and MAX_PIXELS=4) share one
// camera/UART stimulus and are compared against a byte-stream model.
module tb_cam_line_streamer;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ybuss = '0;
  logic       pclk = 1'b0, href = 1'b0, vsync = 1'b0, txHold = 1'b0;
  logic [7:0] rxData = '0;
  logic       newRx = 1'b0;
  logic       busyA, busyB, ovA, ovB;

  int         assertions = 0;
  int         failures = 0;
  logic [7:0] expA [$];
  logic [7:0] expB [$];
  logic [7:0] gotA [$];
  logic [7:0] gotB [$];
  logic       expOvA = 1'b0, expOvB = 1'b0;
  logic       prevStrA = 1'b0, prevStrB = 1'b0, prevTxBusy = 1'b0;

  always #5 clk = ~clk;

  cam_line_streamer_if #(.DATA_W(8)) ifA ();
  cam_line_streamer_if #(.DATA_W(8)) ifB ();

  assign ifA.ybuss = ybuss;   assign ifB.ybuss = ybuss;
  assign ifA.pclk = pclk;     assign ifB.pclk = pclk;
  assign ifA.href = href;     assign ifB.href = href;
  assign ifA.vsync = vsync;   assign ifB.vsync = vsync;
  assign ifA.tx_busy = txHold; assign ifB.tx_busy = txHold;
  assign ifA.rx_data = rxData; assign ifB.rx_data = rxData;
  assign ifA.new_rx_data = newRx; assign ifB.new_rx_data = newRx;

  cam_line_streamer #(.FIFO_DEPTH(DEPTH)) dutMain (
    .clk(clk), .rst(rst), .bus(ifA), .busy_o(busyA), .overflow_o(ovA)
  );

  cam_line_streamer #(.FIFO_DEPTH(DEPTH), .MAX_PIXELS(4)) dutCap (
    .clk(clk), .rst(rst), .bus(ifB), .busy_o(busyB), .overflow_o(ovB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Per-strobe comparison against the expected byte streams.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifA.new_tx_data) begin
        gotA.push_back(ifA.tx_data);
        checkOutput("byteExpectedA", expA.size() > 0, 1);
        if (expA.size() > 0) checkOutput("txDataA", ifA.tx_data, expA.pop_front());
        checkOutput("strobeSpacingA", prevStrA, 0);
        checkOutput("txBusyRespectA", prevTxBusy, 0);
      end
      if (ifB.new_tx_data) begin
        gotB.push_back(ifB.tx_data);
        checkOutput("byteExpectedB", expB.size() > 0, 1);
        if (expB.size() > 0) checkOutput("txDataB", ifB.tx_data, expB.pop_front());
        checkOutput("strobeSpacingB", prevStrB, 0);
        checkOutput("txBusyRespectB", prevTxBusy, 0);
      end
    end
    prevStrA   <= ifA.new_tx_data;
    prevStrB   <= ifB.new_tx_data;
    prevTxBusy <= txHold;
  end

  task automatic pushExp(input int d, input logic [7:0] b);
    if (d == 0) expA.push_back(b);
    else        expB.push_back(b);
  endtask

  // Model of one line: tx is blocked for the first heldPixels pixels (the
  // release coinciding with the next strobe), after which the FIFO drains
  // faster than the camera fills it.
  task automatic expectLine(input int d, input int n, input logic [7:0] base, input int heldPixels);
    int cap   = (d == 0) ? 640 : 4;
    int level = 0;
    int acc   = 0;
    logic ov  = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (acc == cap) break;
      if (i < heldPixels && level == DEPTH) begin
        ov = 1'b1;
      end else begin
        pushExp(d, base + 8'(i));
        acc++;
        if (i < heldPixels) level++;
      end
    end
    pushExp(d, acc[15:8]);
    pushExp(d, acc[7:0]);
    if (d == 0) expOvA = ov;
    else        expOvB = ov;
  endtask

  task automatic sendCmd(input logic [7:0] b);
    rxData = b;
    newRx  = 1'b1;
    @(posedge clk); #1;
    newRx  = 1'b0;
  endtask

  task automatic sendPixel(input logic [7:0] v, input logic releaseTx);
    ybuss = v;
    pclk  = 1'b0;
    repeat (3) @(posedge clk);
    #1 pclk = 1'b1;
    repeat (2) @(posedge clk);
    #1 if (releaseTx) txHold = 1'b0;
    @(posedge clk);
    #1 pclk = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic [7:0] base, input int heldPixels, input int vsyncAfter);
    txHold = (heldPixels > 0);
    sendCmd(8'h6C);
    repeat (2) @(posedge clk);
    #1 href = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      sendPixel(base + 8'(i), (heldPixels > 0) && (i == heldPixels));
      if (i + 1 == vsyncAfter) begin
        vsync = 1'b1;
        repeat (4) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1 href = 1'b0;
    repeat (4) @(posedge clk);
    #1 vsync = 1'b0;
    txHold = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int k = 0;
    while ((expA.size() != 0 || expB.size() != 0 || busyA || busyB) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("finishedInTime", k < budget, 1);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("idleBusyA", busyA, 0);
    checkOutput("idleBusyB", busyB, 0);
    checkOutput("overflowA", ovA, expOvA);
    checkOutput("overflowB", ovB, expOvB);
  endtask

  task automatic checkResetState();
    checkOutput("rstTxDataA", ifA.tx_data, 0);
    checkOutput("rstNewTxA", ifA.new_tx_data, 0);
    checkOutput("rstBusyA", busyA, 0);
    checkOutput("rstOverflowA", ovA, 0);
    checkOutput("rstTxDataB", ifB.tx_data, 0);
    checkOutput("rstNewTxB", ifB.new_tx_data, 0);
    checkOutput("rstBusyB", busyB, 0);
    checkOutput("rstOverflowB", ovB, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkResetState();

    // Single pixel
    gotA.delete(); gotB.delete();
    pushExp(0, 8'h5A); pushExp(1, 8'h5A);
    sendCmd(8'h68);
    checkOutput("cmdLatencyA", busyA, 1);
    repeat (3) @(posedge clk);
    #1 href = 1'b1;
    repeat (3) @(posedge clk);
    #1 sendPixel(8'h5A, 1'b0);
    href = 1'b0;
    waitDone(200);
    checkOutput("singleCountA", gotA.size(), 1);
    checkOutput("singleByteA", gotA[0], 8'h5A);

    // Line of 8, with an 'h' sent mid-line that must be ignored
    gotA.delete(); gotB.delete();
    expectLine(0, 8, 8'h10, 0); expectLine(1, 8, 8'h10, 0);
    fork
      applyStimulus(8, 8'h10, 0, 0);
      begin
        repeat (15) @(posedge clk);
        #1 sendCmd(8'h68);
      end
    join
    waitDone(400);
    checkOutput("lineCountA", gotA.size(), 10);
    checkOutput("lineLastPixA", gotA[7], 8'h17);
    checkOutput("lineTrailerLoA", gotA[9], 8'h08);
    checkOutput("lineCapTrailerB", gotB[5], 8'h04);

    // Overflow: tx held for a 20-pixel line
    gotA.delete(); gotB.delete();
    expectLine(0, 20, 8'h20, 20); expectLine(1, 20, 8'h20, 20);
    applyStimulus(20, 8'h20, 20, 0);
    waitDone(600);
    checkOutput("ovfCountA", gotA.size(), 18);
    checkOutput("ovfLastPixA", gotA[15], 8'h2F);
    checkOutput("ovfTrailerLoA", gotA[17], 8'h10);
    checkOutput("ovfStickyA", ovA, 1);

    // Push into a full FIFO in the same cycle as the first pop
    gotA.delete(); gotB.delete();
    expectLine(0, 17, 8'h40, 16); expectLine(1, 17, 8'h40, 16);
    applyStimulus(17, 8'h40, 16, 0);
    waitDone(600);
    checkOutput("fullPushCountA", gotA.size(), 19);
    checkOutput("fullPushPixA", gotA[16], 8'h50);
    checkOutput("fullPushTrailerA", gotA[18], 8'h11);

    // Cap: 10 pixels, second instance stops at 4
    gotA.delete(); gotB.delete();
    expectLine(0, 10, 8'h60, 0); expectLine(1, 10, 8'h60, 0);
    applyStimulus(10, 8'h60, 0, 0);
    waitDone(400);
    checkOutput("capCountB", gotB.size(), 6);
    checkOutput("capLastPixB", gotB[3], 8'h63);
    checkOutput("capTrailerB", gotB[5], 8'h04);
    checkOutput("capFreeTrailerA", gotA[11], 8'h0A);

    // Early end on vsync after pixel 3
    gotA.delete(); gotB.delete();
    expectLine(0, 3, 8'h70, 0); expectLine(1, 3, 8'h70, 0);
    applyStimulus(5, 8'h70, 0, 3);
    waitDone(400);
    checkOutput("vsyncCountA", gotA.size(), 5);
    checkOutput("vsyncPixA", gotA[2], 8'h72);
    checkOutput("vsyncTrailerA", gotA[4], 8'h03);

    // Abort mid-line with an overflowed FIFO
    gotA.delete(); gotB.delete();
    txHold = 1'b1;
    sendCmd(8'h6C);
    repeat (2) @(posedge clk);
    #1 href = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) sendPixel(8'h80 + 8'(i), 1'b0);
    sendCmd(8'h78);
    checkOutput("abortBusyA", busyA, 0);
    checkOutput("abortBusyB", busyB, 0);
    checkOutput("abortOvKeptA", ovA, 1);
    expOvA = 1'b1; expOvB = 1'b0;
    sendPixel(8'hEE, 1'b0);
    href = 1'b0;
    txHold = 1'b0;
    waitDone(200);
    checkOutput("abortNoBytesA", gotA.size(), 0);
    checkOutput("abortNoBytesB", gotB.size(), 0);

    // Reset while a single pixel waits to drain
    gotA.delete(); gotB.delete();
    txHold = 1'b1;
    sendCmd(8'h68);
    repeat (2) @(posedge clk);
    #1 href = 1'b1;
    repeat (3) @(posedge clk);
    #1 sendPixel(8'h33, 1'b0);
    href = 1'b0;
    repeat (4) @(posedge clk);
    #1 checkOutput("drainStuckA", busyA, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkResetState();
    expOvA = 1'b0; expOvB = 1'b0;
    txHold = 1'b0;
    repeat (10) @(posedge clk);
    #1 checkOutput("rstFlushA", gotA.size(), 0);

    // Normal line after reset
    expectLine(0, 3, 8'h90, 0); expectLine(1, 3, 8'h90, 0);
    applyStimulus(3, 8'h90, 0, 0);
    waitDone(300);
    checkOutput("postRstCountA", gotA.size(), 5);
    checkOutput("postRstTrailerA", gotA[4], 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
